// File: rtl/seg7_pkg.sv
// Segment codes and BCD limits shared by the counter and its 7-segment decoder.
// Segment bit order is g..a, active-low (0 = segment lit).
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD codes show blank.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with prescaler, parallel load, wrap pulse and
// registered active-low 7-segment outputs with optional leading-zero blanking.
module bcd_counter_display
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int BLANK_LZ = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  CARRY
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [4*DIGITS-1:0]   bcd_step, bcd_load;
    logic                  carry_q, carry_d;
    logic [7*DIGITS-1:0]   hex_q, hex_d, hex_rst, seg_raw;
    logic                  tick, wrap;

    assign tick = EN && (presc_q == PRESC_MAX);

    // Ripple increment/decrement: a digit only moves when every lower digit wrapped.
    always_comb begin : step_comb
        logic rip;
        rip      = 1'b1;
        bcd_step = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (rip) begin
                if (UP) begin
                    if (bcd_q[4*i +: 4] >= BCD_MAX) begin
                        bcd_step[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_step[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                        rip = 1'b0;
                    end
                end else begin
                    if (bcd_q[4*i +: 4] == 4'd0) begin
                        bcd_step[4*i +: 4] = BCD_MAX;
                    end else begin
                        bcd_step[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                        rip = 1'b0;
                    end
                end
            end
        end
        wrap = rip;
    end

    always_comb begin
        bcd_load = LOAD_VAL;
        for (int i = 0; i < DIGITS; i++) begin
            if (LOAD_VAL[4*i +: 4] > BCD_MAX) begin
                bcd_load[4*i +: 4] = 4'd0;
            end
        end
    end

    always_comb begin
        bcd_d   = bcd_q;
        presc_d = presc_q;
        carry_d = 1'b0;
        if (LOAD) begin
            bcd_d   = bcd_load;
            presc_d = '0;
        end else if (tick) begin
            bcd_d   = bcd_step;
            presc_d = '0;
            carry_d = wrap;
        end else if (EN) begin
            presc_d = presc_q + PW'(1);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (
            .bcd (bcd_q[4*g +: 4]),
            .seg (seg_raw[7*g +: 7])
        );
    end

    // Scan from the top digit down; a digit is a leading zero while everything above is zero.
    always_comb begin : blank_comb
        logic all_zero;
        all_zero = 1'b1;
        hex_d    = seg_raw;
        hex_rst  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (bcd_q[4*i +: 4] == 4'd0);
            if ((BLANK_LZ != 0) && (i >= 1) && all_zero) begin
                hex_d[7*i +: 7] = SEG_BLANK;
            end
            hex_rst[7*i +: 7] = ((BLANK_LZ != 0) && (i >= 1)) ? SEG_BLANK : SEG_0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            presc_q <= '0;
            bcd_q   <= '0;
            carry_q <= 1'b0;
            hex_q   <= hex_rst;
        end else begin
            presc_q <= presc_d;
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            hex_q   <= hex_d;
        end
    end

    assign BCD   = bcd_q;
    assign HEX   = hex_q;
    assign CARRY = carry_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Scoreboard bench for bcd_counter_display (4 digits, divide-by-4) with a second
// leading-zero-blanking instance sharing the same stimulus.
module tb_bcd_counter_display;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [15:0] load_val;
    logic [15:0] bcd_a, bcd_b;
    logic [27:0] hex_a, hex_b;
    logic        carry_a, carry_b;

    typedef struct packed {
        logic [15:0] bcd;
        logic        carry;
        logic [27:0] hex;
        logic [27:0] hexb;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int          m_cnt, m_presc;
    logic        m_carry;
    logic [27:0] m_hex, m_hexb;

    always #5 clk = ~clk;

    bcd_counter_display #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .BLANK_LZ(0)) u_dut (
        .CLOCK_50 (clk),
        .RST      (rst),
        .EN       (en),
        .UP       (up),
        .LOAD     (load),
        .LOAD_VAL (load_val),
        .BCD      (bcd_a),
        .HEX      (hex_a),
        .CARRY    (carry_a)
    );

    bcd_counter_display #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .BLANK_LZ(1)) u_dut_lz (
        .CLOCK_50 (clk),
        .RST      (rst),
        .EN       (en),
        .UP       (up),
        .LOAD     (load),
        .LOAD_VAL (load_val),
        .BCD      (bcd_b),
        .HEX      (hex_b),
        .CARRY    (carry_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] hex_of(input int v, input bit blank);
        logic [27:0] h;
        int p;
        h = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (blank && i >= 1 && v < p) h[7*i +: 7] = 7'b1111111;
            else h[7*i +: 7] = seg_of((v / p) % 10);
            p = p * 10;
        end
        return h;
    endfunction

    function automatic int to_int(input logic [15:0] b);
        int v, p;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] <= 4'd9) v = v + int'(b[4*i +: 4]) * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b;
        int p;
        b = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            b[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return b;
    endfunction

    // Advance the reference model by one edge using the currently driven inputs.
    task automatic model_push();
        exp_t        e;
        logic [27:0] nh, nhb;
        if (rst) begin
            m_cnt   = 0;
            m_presc = 0;
            m_carry = 1'b0;
            m_hex   = {4{S0}};
            m_hexb  = {SB, SB, SB, S0};
        end else begin
            nh  = hex_of(m_cnt, 1'b0);
            nhb = hex_of(m_cnt, 1'b1);
            m_carry = 1'b0;
            if (load) begin
                m_cnt   = to_int(load_val);
                m_presc = 0;
            end else if (en && m_presc == TICK_DIV - 1) begin
                m_presc = 0;
                if (up) begin
                    m_carry = (m_cnt == 9999);
                    m_cnt   = (m_cnt + 1) % 10000;
                end else begin
                    m_carry = (m_cnt == 0);
                    m_cnt   = (m_cnt + 9999) % 10000;
                end
            end else if (en) begin
                m_presc = m_presc + 1;
            end
            m_hex  = nh;
            m_hexb = nhb;
        end
        e.bcd   = to_bcd(m_cnt);
        e.carry = m_carry;
        e.hex   = m_hex;
        e.hexb  = m_hexb;
        sb_q.push_back(e);
    endtask

    // Caller drives inputs at the falling edge; returns at the next falling edge.
    task automatic step();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("bcd",     32'(bcd_a),   32'(e.bcd));
            chk("carry",   32'(carry_a), 32'(e.carry));
            chk("hex",     32'(hex_a),   32'(e.hex));
            chk("bcd_lz",  32'(bcd_b),   32'(e.bcd));
            chk("carry_lz",32'(carry_b), 32'(e.carry));
            chk("hex_lz",  32'(hex_b),   32'(e.hexb));
        end
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        load_val = v;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        m_cnt = 0; m_presc = 0; m_carry = 1'b0; m_hex = '0; m_hexb = '0;
        @(negedge clk);

        // Reset and free-running up count
        step();
        chk("rst_bcd",    32'(bcd_a),   32'h0);
        chk("rst_carry",  32'(carry_a), 32'h0);
        chk("rst_hex",    32'(hex_a),   32'({4{S0}}));
        chk("rst_hex_lz", 32'(hex_b),   32'({SB, SB, SB, S0}));
        rst = 1'b0; en = 1'b1; up = 1'b1;
        steps(40);
        chk("count40", 32'(bcd_a), 32'h0010);

        // Up wrap from 9999
        do_load(16'h9999);
        steps(4);
        chk("upwrap_bcd",   32'(bcd_a),   32'h0000);
        chk("upwrap_carry", 32'(carry_a), 32'h1);
        step();
        chk("upwrap_pulse", 32'(carry_a), 32'h0);

        // Down wrap from 0000, then borrow chain 1000 -> 0999
        up = 1'b0;
        do_load(16'h0000);
        steps(4);
        chk("dnwrap_bcd",   32'(bcd_a),   32'h9999);
        chk("dnwrap_carry", 32'(carry_a), 32'h1);
        do_load(16'h1000);
        steps(4);
        chk("borrow_bcd",   32'(bcd_a),   32'h0999);
        chk("borrow_carry", 32'(carry_a), 32'h0);

        // Invalid digit sanitised, then enable freeze keeps prescaler phase
        up = 1'b1;
        do_load(16'h12F9);
        chk("load_fix", 32'(bcd_a), 32'h1209);
        steps(2);
        en = 1'b0;
        steps(20);
        chk("frozen", 32'(bcd_a), 32'h1209);
        en = 1'b1;
        step();
        chk("resume1", 32'(bcd_a), 32'h1209);
        step();
        chk("resume2", 32'(bcd_a), 32'h1210);

        // Reset beats load; load beats a tick and clears the prescaler
        steps(3);
        rst = 1'b1; load = 1'b1; load_val = 16'h5555;
        step();
        rst = 1'b0; load = 1'b0;
        chk("rst_load", 32'(bcd_a), 32'h0000);
        steps(3);
        do_load(16'h0042);
        chk("load_tick", 32'(bcd_a), 32'h0042);
        steps(3);
        chk("presc_clr", 32'(bcd_a), 32'h0042);
        step();
        chk("after_load_tick", 32'(bcd_a), 32'h0043);

        // Leading-zero blanking
        en = 1'b0;
        do_load(16'h0040);
        step();
        chk("lz_hex",  32'(hex_b), 32'({SB, SB, S4, S0}));
        chk("nlz_hex", 32'(hex_a), 32'({S0, S0, S4, S0}));

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 63) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1) != 0;
            load     = ($urandom_range(0, 15) == 0);
            load_val = 16'($urandom);
            if ($urandom_range(0, 7) == 0) load_val = $urandom_range(0, 1) != 0 ? 16'h9999 : 16'h0000;
            step();
        end
        rst = 1'b0; load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
